// File: rtl/led_flow_pkg.sv
// Shared types and constants for the LED running-light controller.
// Optional build macro: LED_FLOW_BOUNCE_EN (ping-pong instead of rotation).
package led_flow_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_t;

  // Pattern loaded at reset and on recovery from a corrupted (non one-hot) pattern.
  localparam int unsigned LED_ON_RESET = 1;

endpackage

// File: rtl/edge_rise_det.sv
// Registered rising-edge detector for a same-domain level signal.
// rise_out is a registered one-cycle pulse, one clock after sig_in goes high.
module edge_rise_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic sig_in,
  output logic rise_out
);

  logic sig_d;

  // Delay the input and register the rising-edge term.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sig_d    <= 1'b0;
      rise_out <= 1'b0;
    end else begin
      sig_d    <= sig_in;
      rise_out <= sig_in & ~sig_d;
    end
  end

endmodule

// File: rtl/led_flow_ctrl.sv
// One-hot running light driven by rising edges of an upstream toggle.
// Optional build macro: LED_FLOW_BOUNCE_EN -- reverse direction at the ends
// instead of wrapping; direction is then only taken from dir_left when
// leaving S_IDLE.
//
// state   | meaning
// S_IDLE  | run_en low, pattern and step count frozen
// S_LEFT  | running, steps shift toward MSB
// S_RIGHT | running, steps shift toward LSB
module led_flow_ctrl
  import led_flow_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter bit LED_ACT_LOW = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               tick_in,
  input  logic               run_en,
  input  logic               dir_left,
  output logic [LED_NUM-1:0] led_bus,
  output logic [CNT_W-1:0]   step_cnt,
  output logic               wrap_pulse
);

  localparam logic [LED_NUM-1:0] PAT_LSB = LED_NUM'(LED_ON_RESET);
  localparam logic [LED_NUM-1:0] PAT_MSB = PAT_LSB << (LED_NUM - 1);

  state_t             state;
  state_t             state_nxt;
  logic [LED_NUM-1:0] pattern;
  logic [LED_NUM-1:0] pattern_nxt;
  logic               wrap_nxt;
  logic               rise;
  logic               step_ok;
  logic               go_left;
  logic               pat_ok;

  edge_rise_det u_rise (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sig_in    (tick_in),
    .rise_out  (rise)
  );

  // Next state, next pattern and wrap flag for the current cycle.
  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    wrap_nxt    = 1'b0;
    go_left     = dir_left;
    pat_ok      = $onehot(pattern);
    step_ok     = run_en & rise & pat_ok;

`ifdef LED_FLOW_BOUNCE_EN
    // While running, the direction is owned by the state, not by dir_left.
    if (state == S_LEFT) begin
      go_left = 1'b1;
    end else if (state == S_RIGHT) begin
      go_left = 1'b0;
    end
`endif

    if (!run_en) begin
      state_nxt = S_IDLE;
    end else begin
      state_nxt = go_left ? S_LEFT : S_RIGHT;
    end

    if (!pat_ok) begin
      pattern_nxt = PAT_LSB;
    end else if (step_ok) begin
`ifdef LED_FLOW_BOUNCE_EN
      // Reverse on arriving at an end; a step requested past an end
      // (only possible right after S_IDLE exit) reverses immediately.
      if (go_left) begin
        if (pattern == PAT_MSB) begin
          pattern_nxt = pattern >> 1;
          state_nxt   = S_RIGHT;
          wrap_nxt    = 1'b1;
        end else begin
          pattern_nxt = pattern << 1;
          if (pattern_nxt == PAT_MSB) begin
            state_nxt = S_RIGHT;
            wrap_nxt  = 1'b1;
          end
        end
      end else begin
        if (pattern == PAT_LSB) begin
          pattern_nxt = pattern << 1;
          state_nxt   = S_LEFT;
          wrap_nxt    = 1'b1;
        end else begin
          pattern_nxt = pattern >> 1;
          if (pattern_nxt == PAT_LSB) begin
            state_nxt = S_LEFT;
            wrap_nxt  = 1'b1;
          end
        end
      end
`else
      if (go_left) begin
        pattern_nxt = {pattern[LED_NUM-2:0], pattern[LED_NUM-1]};
        wrap_nxt    = (pattern == PAT_MSB);
      end else begin
        pattern_nxt = {pattern[0], pattern[LED_NUM-1:1]};
        wrap_nxt    = (pattern == PAT_LSB);
      end
`endif
    end
  end

  // State, pattern, step counter and wrap pulse registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      pattern    <= PAT_LSB;
      step_cnt   <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      pattern    <= pattern_nxt;
      wrap_pulse <= wrap_nxt;
      if (step_ok) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end
    end
  end

  assign led_bus = LED_ACT_LOW ? ~pattern : pattern;

endmodule
